// File: rtl/uiimx_cfg_seq.sv
// Camera init sequencer: walks a combinational register LUT and issues each
// entry as a bus write, retrying on NACK and honouring in-table delay entries.
module uiimx_cfg_seq #(
  parameter int                IDX_W      = 9,
  parameter int                ADDR_W     = 16,
  parameter int                DATA_W     = 8,
  parameter logic [ADDR_W-1:0] DELAY_ADDR = 16'hFFFF,
  parameter int                DELAY_UNIT = 1000,
  parameter int                MAX_RETRY  = 3
) (
  input  logic                     I_clk,
  input  logic                     I_rst,
  input  logic                     I_start,
  input  logic [IDX_W-1:0]         I_reg_size,
  output logic [IDX_W-1:0]         O_reg_index,
  input  logic [ADDR_W+DATA_W-1:0] I_reg_data,
  output logic                     O_wr_req,
  output logic [ADDR_W-1:0]        O_wr_addr,
  output logic [DATA_W-1:0]        O_wr_data,
  input  logic                     I_wr_ack,
  input  logic                     I_wr_err,
  output logic                     O_busy,
  output logic                     O_done,
  output logic                     O_err,
  output logic [IDX_W-1:0]         O_err_index
);

  localparam int CNT_W = DATA_W + $clog2(DELAY_UNIT + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 1);

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH    = 4'd1,
    S_LATCH    = 4'd2,
    S_WRITE    = 4'd3,
    S_WAIT_ACK = 4'd4,
    S_GAP      = 4'd5,
    S_DELAY    = 4'd6,
    S_NEXT     = 4'd7,
    S_DONE     = 4'd8,
    S_ERROR    = 4'd9
  } state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [IDX_W-1:0]    size_q, size_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic                req_q, req_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic [IDX_W-1:0]    err_idx_q, err_idx_d;
  logic [RTY_W-1:0]    retry_q, retry_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [ADDR_W-1:0]   lut_addr_s;
  logic [DATA_W-1:0]   lut_data_s;
  logic [RTY_W-1:0]    retry_inc_s;
  logic [CNT_W-1:0]    delay_load_s;
  logic                last_idx_s;

  assign lut_addr_s   = I_reg_data[ADDR_W+DATA_W-1:DATA_W];
  assign lut_data_s   = I_reg_data[DATA_W-1:0];
  assign retry_inc_s  = retry_q + RTY_W'(1);
  assign delay_load_s = CNT_W'(lut_data_s) * CNT_W'(DELAY_UNIT);
  assign last_idx_s   = (idx_q == (size_q - IDX_W'(1)));

  // Next-state and next-output computation for the sequencer.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    size_d    = size_q;
    addr_d    = addr_q;
    data_d    = data_q;
    req_d     = req_q;
    busy_d    = busy_q;
    done_d    = done_q;
    err_d     = err_q;
    err_idx_d = err_idx_q;
    retry_d   = retry_q;
    cnt_d     = cnt_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (I_start) begin
          size_d    = I_reg_size;
          idx_d     = {IDX_W{1'b0}};
          done_d    = 1'b0;
          err_d     = 1'b0;
          err_idx_d = {IDX_W{1'b0}};
          if (I_reg_size == {IDX_W{1'b0}}) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = S_FETCH;
            busy_d  = 1'b1;
          end
        end else begin
          state_d = state_q;
        end
      end
      S_FETCH: begin
        state_d = S_LATCH;
      end
      S_LATCH: begin
        addr_d  = lut_addr_s;
        data_d  = lut_data_s;
        retry_d = {RTY_W{1'b0}};
        if (lut_addr_s == DELAY_ADDR) begin
          state_d = S_DELAY;
          cnt_d   = delay_load_s;
        end else begin
          // Request rises together with WRITE so a retry gap is one low cycle.
          state_d = S_WRITE;
          req_d   = 1'b1;
        end
      end
      S_WRITE: begin
        state_d = S_WAIT_ACK;
        req_d   = 1'b1;
      end
      S_WAIT_ACK: begin
        if (I_wr_ack) begin
          req_d = 1'b0;
          if (I_wr_err) begin
            retry_d = retry_inc_s;
            if (int'(retry_inc_s) < MAX_RETRY) begin
              state_d = S_GAP;
            end else begin
              state_d   = S_ERROR;
              err_d     = 1'b1;
              busy_d    = 1'b0;
              err_idx_d = idx_q;
            end
          end else begin
            state_d = S_NEXT;
          end
        end else begin
          state_d = S_WAIT_ACK;
        end
      end
      S_GAP: begin
        state_d = S_WRITE;
        req_d   = 1'b1;
      end
      S_DELAY: begin
        if (cnt_q <= CNT_W'(1)) begin
          state_d = S_NEXT;
          cnt_d   = {CNT_W{1'b0}};
        end else begin
          cnt_d   = cnt_q - CNT_W'(1);
        end
      end
      S_NEXT: begin
        if (last_idx_s) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          state_d = S_FETCH;
          idx_d   = idx_q + IDX_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state_q   <= S_IDLE;
      idx_q     <= {IDX_W{1'b0}};
      size_q    <= {IDX_W{1'b0}};
      addr_q    <= {ADDR_W{1'b0}};
      data_q    <= {DATA_W{1'b0}};
      req_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      err_idx_q <= {IDX_W{1'b0}};
      retry_q   <= {RTY_W{1'b0}};
      cnt_q     <= {CNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      size_q    <= size_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      req_q     <= req_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      err_q     <= err_d;
      err_idx_q <= err_idx_d;
      retry_q   <= retry_d;
      cnt_q     <= cnt_d;
    end
  end

  assign O_reg_index = idx_q;
  assign O_wr_req    = req_q;
  assign O_wr_addr   = addr_q;
  assign O_wr_data   = data_q;
  assign O_busy      = busy_q;
  assign O_done      = done_q;
  assign O_err       = err_q;
  assign O_err_index = err_idx_q;

endmodule

// File: tb/tb_uiimx_cfg_seq.sv
// Bench for uiimx_cfg_seq: transaction-level model of expected bus writes and
// request spacing, randomized tables/NACKs, plus directed boundary scenarios.
module tb_uiimx_cfg_seq;

  localparam int IDX_W = 9;
  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int DU = 10;
  localparam int MR = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                     rst;
  logic                     start;
  logic [IDX_W-1:0]         size;
  logic [IDX_W-1:0]         idx;
  logic [ADDR_W+DATA_W-1:0] reg_data;
  logic                     req;
  logic [ADDR_W-1:0]        waddr;
  logic [DATA_W-1:0]        wdata;
  logic                     ack;
  logic                     werr;
  logic                     busy;
  logic                     done;
  logic                     err;
  logic [IDX_W-1:0]         err_idx;

  logic [15:0] tbl_addr [0:511];
  logic [7:0]  tbl_data [0:511];
  int          nack     [0:511];
  int          attempts [0:511];

  assign reg_data = {tbl_addr[idx], tbl_data[idx]};

  uiimx_cfg_seq #(
    .IDX_W(IDX_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .DELAY_ADDR(16'hFFFF), .DELAY_UNIT(DU), .MAX_RETRY(MR)
  ) dut (
    .I_clk(clk), .I_rst(rst), .I_start(start), .I_reg_size(size),
    .O_reg_index(idx), .I_reg_data(reg_data), .O_wr_req(req),
    .O_wr_addr(waddr), .O_wr_data(wdata), .I_wr_ack(ack), .I_wr_err(werr),
    .O_busy(busy), .O_done(done), .O_err(err), .O_err_index(err_idx)
  );

  typedef struct {
    logic [15:0] a;
    logic [7:0]  d;
    int          gap;
  } exp_t;

  exp_t exp_q [$];
  exp_t obs_q [$];
  exp_t cur;
  int   checks = 0;
  int   errors = 0;
  logic exp_done, exp_err;
  int   exp_err_idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  // Expected bus writes: each write entry yields min(nacks+1, MR) attempts;
  // gap = low cycles before the request (2 after start, 3 after an ack,
  // 1 before a retry), each delay entry adding 3 + max(data*DU, 1).
  task automatic build_model(input int sz);
    int g;
    int n;
    exp_t e;
    exp_q.delete();
    exp_done = 1'b1;
    exp_err = 1'b0;
    exp_err_idx = 0;
    g = 2;
    for (int i = 0; i < sz; i++) begin
      if (tbl_addr[i] == 16'hFFFF) begin
        n = int'(tbl_data[i]) * DU;
        if (n < 1) n = 1;
        g += 3 + n;
      end else begin
        n = nack[i] + 1;
        if (n > MR) n = MR;
        for (int k = 0; k < n; k++) begin
          e.a = tbl_addr[i];
          e.d = tbl_data[i];
          e.gap = (k == 0) ? g : 1;
          exp_q.push_back(e);
        end
        if (nack[i] >= MR) begin
          exp_done = 1'b0;
          exp_err = 1'b1;
          exp_err_idx = i;
          break;
        end
        g = 3;
      end
    end
  endtask

  // Bus master model: ack 2..4 cycles after request, NACK per schedule,
  // occasional stray acks while no request is pending.
  initial begin
    int wc;
    int lat;
    ack = 1'b0;
    werr = 1'b0;
    wc = 0;
    lat = 2;
    forever begin
      @(posedge clk);
      #1;
      ack = 1'b0;
      werr = 1'b0;
      if (rst) begin
        wc = 0;
      end else if (req) begin
        if (wc == 0) lat = $urandom_range(2, 4);
        wc++;
        if (wc == lat) begin
          ack = 1'b1;
          werr = (attempts[idx] < nack[idx]);
          attempts[idx]++;
          wc = 0;
        end
      end else begin
        wc = 0;
        if ($urandom_range(0, 7) == 0) begin
          ack = 1'b1;
          werr = 1'($urandom_range(0, 1));
        end
      end
    end
  end

  // Cycle-by-cycle comparison of DUT outputs against the expected write stream.
  initial begin
    int   low_cnt;
    logic prev_req;
    exp_t e;
    exp_t o;
    low_cnt = 0;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        low_cnt = 0;
        prev_req = 1'b0;
      end else begin
        if (done && err) chk("done_err_excl", 32'(done & err), 32'd0);
        if (busy && (done || err)) chk("busy_excl", 32'(busy & (done | err)), 32'd0);
        if (req && !prev_req) begin
          chk("req_expected", 32'(exp_q.size() > 0), 32'd1);
          o.a = waddr;
          o.d = wdata;
          o.gap = low_cnt;
          obs_q.push_back(o);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wr_addr", 32'(waddr), 32'(e.a));
            chk("wr_data", 32'(wdata), 32'(e.d));
            chk("req_gap", 32'(low_cnt), 32'(e.gap));
            cur = e;
          end
        end else if (req) begin
          if (waddr !== cur.a || wdata !== cur.d) begin
            chk("wr_stable", 32'({waddr, wdata}), 32'({cur.a, cur.d}));
          end
        end
        if (req) low_cnt = 0;
        else     low_cnt++;
        if (start && !busy) low_cnt = 0;
        prev_req = req;
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c;
    c = 0;
    while (busy && c < 20000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk({tag, "_timeout"}, 32'(busy), 32'd0);
    repeat (12) @(posedge clk);
    #1;
    chk({tag, "_missing_req"}, 32'(exp_q.size()), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'(exp_done));
    chk({tag, "_err"}, 32'(err), 32'(exp_err));
    chk({tag, "_err_idx"}, 32'(err_idx), 32'(exp_err_idx));
    chk({tag, "_req_idle"}, 32'(req), 32'd0);
  endtask

  task automatic run_seq(input string tag, input int sz, input bit mid);
    int c;
    for (int i = 0; i < 512; i++) attempts[i] = 0;
    obs_q.delete();
    build_model(sz);
    size = IDX_W'(sz);
    pulse_start();
    chk({tag, "_busy_at_start"}, 32'(busy), 32'd1);
    chk({tag, "_clr_at_start"}, 32'(done | err), 32'd0);
    if (mid) begin
      c = 0;
      while (busy && int'(idx) != sz / 2 && c < 20000) begin
        @(posedge clk);
        #1;
        c++;
      end
      if (busy) begin
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
      end
    end
    wait_idle(tag);
  endtask

  task automatic clear_tbl();
    for (int i = 0; i < 512; i++) begin
      tbl_addr[i] = 16'h0000;
      tbl_data[i] = 8'h00;
      nack[i] = 0;
    end
  endtask

  initial begin
    int c;
    int sz;
    rst = 1'b1;
    start = 1'b0;
    size = '0;
    clear_tbl();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_idx", 32'(idx), 32'd0);
    chk("rst_addr_data", 32'({waddr, wdata}), 32'd0);
    rst = 1'b0;

    // Plain three-entry table.
    tbl_addr[0] = 16'h3000; tbl_data[0] = 8'h01;
    tbl_addr[1] = 16'h3001; tbl_data[1] = 8'h00;
    tbl_addr[2] = 16'h3002; tbl_data[2] = 8'h01;
    run_seq("basic", 3, 1'b0);
    chk("basic_nreq", 32'(obs_q.size()), 32'd3);
    if (obs_q.size() == 3) begin
      chk("basic_a0", 32'({obs_q[0].a, obs_q[0].d}), 32'h300001);
      chk("basic_a1", 32'({obs_q[1].a, obs_q[1].d}), 32'h300100);
      chk("basic_a2", 32'({obs_q[2].a, obs_q[2].d}), 32'h300201);
      chk("basic_gap2", 32'(obs_q[2].gap), 32'd3);
    end

    // Delay entry of 2 units between two writes.
    tbl_addr[1] = 16'hFFFF; tbl_data[1] = 8'h02;
    run_seq("delay", 3, 1'b0);
    chk("delay_nreq", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() == 2) begin
      chk("delay_a1", 32'(obs_q[1].a), 32'h3002);
      chk("delay_gap", 32'(obs_q[1].gap), 32'd26);
    end

    // Two NACKs on index 1, then success.
    tbl_addr[1] = 16'h3001; tbl_data[1] = 8'h22;
    nack[1] = 2;
    run_seq("retry", 3, 1'b0);
    chk("retry_nreq", 32'(obs_q.size()), 32'd5);
    if (obs_q.size() == 5) begin
      chk("retry_a3", 32'(obs_q[3].a), 32'h3001);
      chk("retry_gap3", 32'(obs_q[3].gap), 32'd1);
    end

    // Index 2 exhausts its retries, then a clean restart.
    nack[1] = 0;
    nack[2] = 3;
    run_seq("abort", 3, 1'b0);
    chk("abort_err_idx_lit", 32'(err_idx), 32'd2);
    chk("abort_nreq", 32'(obs_q.size()), 32'd5);
    nack[2] = 0;
    run_seq("restart", 3, 1'b0);
    if (obs_q.size() > 0) chk("restart_first", 32'(obs_q[0].a), 32'h3000);
    else chk("restart_first", 32'd0, 32'h3000);
    nack[2] = 3;
    run_seq("abort2", 3, 1'b0);

    // Empty table: done one cycle after start, no requests.
    build_model(0);
    size = '0;
    pulse_start();
    chk("size0_done", 32'(done), 32'd1);
    chk("size0_err", 32'(err), 32'd0);
    chk("size0_busy", 32'(busy), 32'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("size0_req", 32'(req), 32'd0);

    // Reset while a request is pending at index 5.
    clear_tbl();
    for (int i = 0; i < 8; i++) begin
      tbl_addr[i] = 16'h3100 + 16'(i);
      tbl_data[i] = 8'(i * 3);
    end
    for (int i = 0; i < 512; i++) attempts[i] = 0;
    build_model(8);
    size = 9'd8;
    pulse_start();
    c = 0;
    while (!(req && idx == 9'd5) && c < 2000) begin
      @(posedge clk);
      #1;
      c++;
    end
    chk("rst_mid_reach", 32'(req && idx == 9'd5), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_req", 32'(req), 32'd0);
    chk("rst_mid_busy", 32'(busy), 32'd0);
    chk("rst_mid_idx", 32'(idx), 32'd0);
    chk("rst_mid_addr_data", 32'({waddr, wdata}), 32'd0);
    chk("rst_mid_flags", 32'({done, err, err_idx}), 32'd0);
    rst = 1'b0;
    exp_q.delete();
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_resume", 32'({req, busy}), 32'd0);

    // Start pulse mid-sequence must be ignored.
    run_seq("mid_start", 6, 1'b1);

    // Randomized tables, delays and NACK schedules.
    for (int r = 0; r < 16; r++) begin
      clear_tbl();
      sz = $urandom_range(1, 10);
      for (int i = 0; i < sz; i++) begin
        if ($urandom_range(0, 4) == 0) begin
          tbl_addr[i] = 16'hFFFF;
          tbl_data[i] = 8'($urandom_range(0, 3));
        end else begin
          tbl_addr[i] = 16'($urandom_range(0, 16'hFFFE));
          tbl_data[i] = 8'($urandom_range(0, 255));
          if ($urandom_range(0, 5) == 0) nack[i] = $urandom_range(1, 3);
        end
      end
      run_seq("rand", sz, ($urandom_range(0, 3) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
